// File: rtl/npu_stream_feeder.sv
// Streams an image tensor and then a kernel tensor from a 1-cycle-latency read port
// onto an AXI-stream master. Reads are prefetched into a 2-entry FIFO that drives the
// stream outputs directly; tuser carries {rows, cols, num_channels} of the current tensor.
module npu_stream_feeder #(
   parameter int ADDR_WIDTH         = 13,
   parameter int DATA_WIDTH         = 8,
   parameter int MAX_CHANNELS       = 64,
   parameter int NUM_CHANNELS_WIDTH = $clog2(MAX_CHANNELS + 1)
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic                                        start,
   input  logic [ADDR_WIDTH-1:0]                       img_row,
   input  logic [ADDR_WIDTH-1:0]                       img_col,
   input  logic [ADDR_WIDTH-1:0]                       ker_row,
   input  logic [ADDR_WIDTH-1:0]                       ker_col,
   input  logic [NUM_CHANNELS_WIDTH-1:0]               num_channels,
   input  logic [ADDR_WIDTH-1:0]                       img_base,
   input  logic [ADDR_WIDTH-1:0]                       ker_base,
   output logic                                        busy,
   output logic                                        done,
   output logic                                        err,
   output logic                                        mem_rd_en,
   output logic [ADDR_WIDTH-1:0]                       mem_rd_addr,
   input  logic [DATA_WIDTH-1:0]                       mem_rd_data,
   output logic signed [DATA_WIDTH-1:0]                m_axis_tdata,
   output logic                                        m_axis_tvalid,
   input  logic                                        m_axis_tready,
   output logic                                        m_axis_tlast,
   output logic [2*ADDR_WIDTH+NUM_CHANNELS_WIDTH-1:0]  m_axis_tuser
);

   localparam int BW = 2 * ADDR_WIDTH;
   localparam int UW = 2 * ADDR_WIDTH + NUM_CHANNELS_WIDTH;

   typedef enum logic [1:0] {StIdle, StSendImg, StSendKer, StFinish} state_t;

   state_t                        state_q;
   logic [ADDR_WIDTH-1:0]         img_row_q, img_col_q, ker_row_q, ker_col_q;
   logic [ADDR_WIDTH-1:0]         img_base_q, ker_base_q;
   logic [NUM_CHANNELS_WIDTH-1:0] ch_q;
   logic [BW-1:0]                 img_beats_q, ker_beats_q;
   logic [BW-1:0]                 idx_q;
   logic                          ker_issued_q;

   // In-flight read: data appears on mem_rd_data this cycle and is pushed at the next edge
   logic                          infl_vld_q;
   logic                          infl_last_q;
   logic                          infl_end_q;
   logic [UW-1:0]                 infl_user_q;

   // 2-entry output FIFO
   logic [DATA_WIDTH-1:0]         fifo_data_q [2];
   logic                          fifo_last_q [2];
   logic                          fifo_end_q  [2];
   logic [UW-1:0]                 fifo_user_q [2];
   logic                          wr_ptr_q, rd_ptr_q;
   logic [1:0]                    fifo_cnt_q;

   logic                          cur_ker;
   logic [ADDR_WIDTH-1:0]         cur_base;
   logic [BW-1:0]                 cur_beats;
   logic [UW-1:0]                 cur_user;
   logic                          issue_last;
   logic                          issue_phase;
   logic                          space_ok;
   logic                          issue;
   logic                          push;
   logic                          pop;
   logic                          head_end;
   logic                          start_bad;

   // Current tensor selection, read issue decision and stream outputs
   always_comb begin
      cur_ker     = (state_q == StSendKer);
      cur_base    = cur_ker ? ker_base_q : img_base_q;
      cur_beats   = cur_ker ? ker_beats_q : img_beats_q;
      cur_user    = cur_ker ? {ker_row_q, ker_col_q, ch_q} : {img_row_q, img_col_q, ch_q};
      issue_last  = (idx_q == cur_beats - BW'(1));
      issue_phase = (state_q == StSendImg) || ((state_q == StSendKer) && !ker_issued_q);

      m_axis_tvalid = (fifo_cnt_q != 2'd0);
      m_axis_tdata  = m_axis_tvalid ? fifo_data_q[rd_ptr_q] : '0;
      m_axis_tlast  = m_axis_tvalid ? fifo_last_q[rd_ptr_q] : 1'b0;
      m_axis_tuser  = m_axis_tvalid ? fifo_user_q[rd_ptr_q] : '0;
      head_end      = m_axis_tvalid & fifo_end_q[rd_ptr_q];

      pop  = m_axis_tvalid & m_axis_tready;
      push = infl_vld_q;
      // A read issued now lands two edges later; count the beat leaving this cycle as free
      space_ok = ({1'b0, fifo_cnt_q} + {2'b00, infl_vld_q}) < (3'd2 + {2'b00, pop});
      issue    = issue_phase & space_ok;

      mem_rd_en   = issue;
      mem_rd_addr = issue ? (cur_base + idx_q[ADDR_WIDTH-1:0]) : '0;

      start_bad = (img_row == '0) || (img_col == '0) || (ker_row == '0) ||
                  (ker_col == '0) || (num_channels == '0);
   end

   // Job control FSM with registered busy/done/err
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         busy         <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
         img_row_q    <= '0;
         img_col_q    <= '0;
         ker_row_q    <= '0;
         ker_col_q    <= '0;
         img_base_q   <= '0;
         ker_base_q   <= '0;
         ch_q         <= '0;
         img_beats_q  <= '0;
         ker_beats_q  <= '0;
         idx_q        <= '0;
         ker_issued_q <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  if (start_bad) begin
                     err <= 1'b1;
                  end else begin
                     img_row_q    <= img_row;
                     img_col_q    <= img_col;
                     ker_row_q    <= ker_row;
                     ker_col_q    <= ker_col;
                     img_base_q   <= img_base;
                     ker_base_q   <= ker_base;
                     ch_q         <= num_channels;
                     img_beats_q  <= BW'(img_row) * BW'(img_col);
                     ker_beats_q  <= BW'(ker_row) * BW'(ker_col);
                     idx_q        <= '0;
                     ker_issued_q <= 1'b0;
                     busy         <= 1'b1;
                     state_q      <= StSendImg;
                  end
               end
            end
            StSendImg: begin
               if (issue) begin
                  if (issue_last) begin
                     idx_q   <= '0;
                     state_q <= StSendKer;
                  end else begin
                     idx_q <= idx_q + BW'(1);
                  end
               end
            end
            StSendKer: begin
               if (issue) begin
                  if (issue_last) begin
                     ker_issued_q <= 1'b1;
                  end else begin
                     idx_q <= idx_q + BW'(1);
                  end
               end
               // Only kernel entries carry the job-end flag
               if (pop && head_end) begin
                  done    <= 1'b1;
                  state_q <= StFinish;
               end
            end
            StFinish: begin
               busy    <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // In-flight read tracking: attributes travel alongside the memory latency
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         infl_vld_q  <= 1'b0;
         infl_last_q <= 1'b0;
         infl_end_q  <= 1'b0;
         infl_user_q <= '0;
      end else begin
         infl_vld_q  <= issue;
         infl_last_q <= issue_last;
         infl_end_q  <= cur_ker & issue_last;
         infl_user_q <= cur_user;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         fifo_cnt_q <= 2'd0;
      end else begin
         if (push) wr_ptr_q <= ~wr_ptr_q;
         if (pop)  rd_ptr_q <= ~rd_ptr_q;
         fifo_cnt_q <= fifo_cnt_q + {1'b0, push} - {1'b0, pop};
      end
   end

   // FIFO storage; outputs are gated by valid so the contents need no reset
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data_q[wr_ptr_q] <= mem_rd_data;
         fifo_last_q[wr_ptr_q] <= infl_last_q;
         fifo_end_q[wr_ptr_q]  <= infl_end_q;
         fifo_user_q[wr_ptr_q] <= infl_user_q;
      end
   end

endmodule

// File: tb/tb_npu_stream_feeder.sv
// Scoreboard bench for npu_stream_feeder: stimulus pushes expected read addresses and
// beats into queues, a negedge monitor pops and compares on every read and handshake.
module tb_npu_stream_feeder;

   localparam int AW  = 13;
   localparam int DW  = 8;
   localparam int NCW = 7;
   localparam int UW  = 2 * AW + NCW;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
      logic [UW-1:0] user;
   } beat_t;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 start;
   logic [AW-1:0]        img_row, img_col, ker_row, ker_col, img_base, ker_base;
   logic [NCW-1:0]       num_channels;
   logic                 busy, done, err;
   logic                 mem_rd_en;
   logic [AW-1:0]        mem_rd_addr;
   logic [DW-1:0]        mem_rd_data;
   logic signed [DW-1:0] tdata;
   logic                 tvalid, tready, tlast;
   logic [UW-1:0]        tuser;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int hs_cnt  = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   int last_tlast_cyc = -10;
   int issued = 0;
   int popped = 0;
   bit rand_mode = 1'b0;

   beat_t         exp_q[$];
   logic [AW-1:0] addr_q[$];

   npu_stream_feeder #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .MAX_CHANNELS(64),
      .NUM_CHANNELS_WIDTH(NCW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .img_row(img_row),
      .img_col(img_col),
      .ker_row(ker_row),
      .ker_col(ker_col),
      .num_channels(num_channels),
      .img_base(img_base),
      .ker_base(ker_base),
      .busy(busy),
      .done(done),
      .err(err),
      .mem_rd_en(mem_rd_en),
      .mem_rd_addr(mem_rd_addr),
      .mem_rd_data(mem_rd_data),
      .m_axis_tdata(tdata),
      .m_axis_tvalid(tvalid),
      .m_axis_tready(tready),
      .m_axis_tlast(tlast),
      .m_axis_tuser(tuser)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
      logic [31:0] t;
      t = 32'(a) * 32'd13 + 32'd7;
      return t[DW-1:0];
   endfunction

   // Memory model: data valid the cycle after the read enable
   always @(posedge clk) begin
      if (mem_rd_en) mem_rd_data <= mem_f(mem_rd_addr);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_beat(input int a, input bit last, input int r, input int c,
                            input int ch);
      beat_t b;
      b.data = mem_f(AW'(a));
      b.last = last;
      b.user = {AW'(r), AW'(c), NCW'(ch)};
      exp_q.push_back(b);
      addr_q.push_back(AW'(a));
   endtask

   task automatic push_tensor(input int base, input int r, input int c, input int ch);
      for (int i = 0; i < r * c; i++) push_beat((base + i) % 8192, (i == r * c - 1), r, c, ch);
   endtask

   task automatic drive(input int ib, input int kb, input int ir, input int ic,
                        input int kr, input int kc, input int ch);
      img_base = AW'(ib);
      ker_base = AW'(kb);
      img_row  = AW'(ir);
      img_col  = AW'(ic);
      ker_row  = AW'(kr);
      ker_col  = AW'(kc);
      num_channels = NCW'(ch);
   endtask

   // Returns #1 after the accept edge; inputs are scrambled to prove they were latched
   task automatic launch(input int ib, input int kb, input int ir, input int ic,
                         input int kr, input int kc, input int ch);
      @(posedge clk); #1;
      drive(ib, kb, ir, ic, kr, kc, ch);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      drive(777, 333, 5, 7, 3, 9, 11);
      chk("busy_after_accept", 64'(busy), 64'(1));
   endtask

   task automatic wait_done(input string tag);
      int d0;
      int i;
      d0 = done_cnt;
      i  = 0;
      while (done_cnt == d0 && i < 3000) begin
         @(posedge clk);
         i++;
      end
      #1;
      chk({tag, "_done_seen"}, 64'(done_cnt - d0), 64'(1));
      chk({tag, "_busy_low_after_finish"}, 64'(busy), 64'(0));
      repeat (2) @(posedge clk);
      #1;
      chk({tag, "_done_single_pulse"}, 64'(done_cnt - d0), 64'(1));
      chk({tag, "_beats_left"}, 64'(exp_q.size()), 64'(0));
      chk({tag, "_reads_left"}, 64'(addr_q.size()), 64'(0));
   endtask

   // tready: held high, or a coin flip each cycle in backpressure mode
   initial begin
      tready = 1'b1;
      forever begin
         @(posedge clk); #1;
         tready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor / scoreboard
   always @(negedge clk) begin : mon
      bit            stall_prev;
      logic [41:0]   held;
      bit            pop;
      beat_t         e;
      if (rst) begin
         issued     = 0;
         popped     = 0;
         stall_prev = 1'b0;
      end else begin
         pop = tvalid && tready;
         if (stall_prev)
            chk("stall_hold", 64'({tvalid, tdata, tlast, tuser}), 64'({1'b1, held}));
         stall_prev = tvalid && !tready;
         held = {tdata, tlast, tuser};
         if (mem_rd_en) begin
            chk("rd_occupancy_bound", 64'((issued - popped - int'(pop)) < 2), 64'(1));
            if (addr_q.size() == 0) chk("rd_unexpected", 64'(mem_rd_addr), 64'hdead);
            else chk("rd_addr", 64'(mem_rd_addr), 64'(addr_q.pop_front()));
            issued++;
         end
         if (pop) begin
            if (exp_q.size() == 0) begin
               chk("beat_unexpected", 64'({tdata, tlast, tuser}), 64'hdead);
            end else begin
               e = exp_q.pop_front();
               chk("beat", 64'({tdata, tlast, tuser}), 64'({e.data, e.last, e.user}));
            end
            popped++;
            hs_cnt++;
            if (tlast) last_tlast_cyc = cyc;
         end
         if (done) begin
            done_cnt++;
            chk("done_after_last_beat", 64'(cyc), 64'(last_tlast_cyc + 1));
         end
         if (err) err_cnt++;
      end
   end

   initial begin
      int h0;
      int e0;
      int i;
      rst   = 1'b1;
      start = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0);

      // Reset state
      @(posedge clk); #1;
      chk("reset_outputs", 64'({tvalid, tlast, tdata, tuser, mem_rd_en, mem_rd_addr,
                                busy, done, err}), 64'(0));
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Basic job with latency checks: img 2x3 @0, ker 2x2 @100, ch 1
      push_tensor(0, 2, 3, 1);
      push_tensor(100, 2, 2, 1);
      launch(0, 100, 2, 3, 2, 2, 1);
      chk("lat_rd_en_cycle1", 64'(mem_rd_en), 64'(1));
      chk("lat_tvalid_cycle1", 64'(tvalid), 64'(0));
      @(posedge clk); #1;
      chk("lat_tvalid_cycle2", 64'(tvalid), 64'(0));
      @(posedge clk); #1;
      chk("lat_tvalid_cycle3", 64'(tvalid), 64'(1));
      wait_done("basic");

      // Backpressure: same job, tready random
      rand_mode = 1'b1;
      push_tensor(0, 2, 3, 1);
      push_tensor(100, 2, 2, 1);
      launch(0, 100, 2, 3, 2, 2, 1);
      wait_done("backpressure");
      rand_mode = 1'b0;

      // Address wrap: img 1x4 @8190, ker 1x1 @5, ch 3
      push_beat(8190, 1'b0, 1, 4, 3);
      push_beat(8191, 1'b0, 1, 4, 3);
      push_beat(0, 1'b0, 1, 4, 3);
      push_beat(1, 1'b1, 1, 4, 3);
      push_beat(5, 1'b1, 1, 1, 3);
      launch(8190, 5, 1, 4, 1, 1, 3);
      wait_done("wrap");

      // Rejection: ker_col = 0, then num_channels = 0
      e0 = err_cnt;
      h0 = hs_cnt;
      @(posedge clk); #1;
      drive(0, 100, 2, 3, 2, 0, 1);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("reject_err_pulse", 64'(err), 64'(1));
      chk("reject_busy_low", 64'(busy), 64'(0));
      @(posedge clk); #1;
      chk("reject_err_one_cycle", 64'(err), 64'(0));
      drive(0, 100, 2, 3, 2, 2, 0);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("reject_ch0_err_pulse", 64'(err), 64'(1));
      repeat (5) @(posedge clk);
      #1;
      chk("reject_no_beats", 64'(hs_cnt - h0), 64'(0));
      chk("reject_tvalid_low", 64'(tvalid), 64'(0));
      chk("reject_err_count", 64'(err_cnt - e0), 64'(2));

      // Start while busy is ignored without err
      e0 = err_cnt;
      push_tensor(50, 1, 3, 4);
      push_tensor(200, 1, 2, 4);
      launch(50, 200, 1, 3, 1, 2, 4);
      repeat (2) @(posedge clk);
      #1;
      drive(0, 0, 2, 2, 2, 2, 1);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      drive(9, 9, 0, 0, 0, 0, 0);
      wait_done("busy_start");
      chk("busy_start_no_err", 64'(err_cnt - e0), 64'(0));
      repeat (6) @(posedge clk);
      #1;
      chk("busy_start_no_second_job", 64'(busy), 64'(0));

      // Reset mid-job after beat 3, then a fresh complete job
      push_tensor(0, 2, 3, 1);
      push_tensor(100, 2, 2, 1);
      h0 = hs_cnt;
      launch(0, 100, 2, 3, 2, 2, 1);
      i = 0;
      while ((hs_cnt - h0) < 3 && i < 500) begin
         @(negedge clk); #1;
         i++;
      end
      chk("midreset_reached_beat3", 64'(hs_cnt - h0), 64'(3));
      rst = 1'b1;
      #1;
      chk("midreset_tvalid_low", 64'(tvalid), 64'(0));
      chk("midreset_idle", 64'({busy, mem_rd_en, done, err}), 64'(0));
      exp_q.delete();
      addr_q.delete();
      @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
      push_tensor(0, 2, 3, 1);
      push_tensor(100, 2, 2, 1);
      launch(0, 100, 2, 3, 2, 2, 1);
      wait_done("after_reset");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/npu_stream_feeder.md
NPU_STREAM_FEEDER -- requirements
Module: npu_stream_feeder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 13, the memory address and dimension width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, the element width.
REQ-003 SHALL have parameter MAX_CHANNELS, default 64, the maximum channel count.
REQ-004 SHALL have parameter NUM_CHANNELS_WIDTH, default $clog2(MAX_CHANNELS+1), the channel-field width.
REQ-005 SHALL have port clk, input, 1, the single clock for all logic.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port start, input, 1, a one-cycle request to send a job.
REQ-008 SHALL have ports img_row, img_col, ker_row, ker_col, input, ADDR_WIDTH each, the tensor dimensions.
REQ-009 SHALL have port num_channels, input, NUM_CHANNELS_WIDTH, the channel count.
REQ-010 SHALL have ports img_base and ker_base, input, ADDR_WIDTH each, the tensor start addresses.
REQ-011 SHALL have port busy, input... correction: busy SHALL be an output, 1, high while a job is active.
REQ-012 SHALL have port done, output, 1, a one-cycle pulse at job end.
REQ-013 SHALL have port err, output, 1, a one-cycle pulse when a start is rejected.
REQ-014 SHALL have ports mem_rd_en (output, 1), mem_rd_addr (output, ADDR_WIDTH) and mem_rd_data (input, DATA_WIDTH), a read port whose data is valid exactly 1 cycle after mem_rd_en.
REQ-015 SHALL have AXI-stream master ports m_axis_tdata (signed, DATA_WIDTH), m_axis_tvalid (output), m_axis_tready (input), m_axis_tlast (output) and m_axis_tuser (2*ADDR_WIDTH+NUM_CHANNELS_WIDTH).

Function
REQ-016 SHALL implement the states IDLE, SEND_IMG, SEND_KER and FINISH.
REQ-017 SHALL register all start-time inputs in IDLE when start=1, so that later input changes have no effect.
REQ-018 SHALL accept a start only in IDLE; a start seen in any other state SHALL be ignored without asserting err.
REQ-019 SHALL reject a start when any dimension is 0 or num_channels is 0, pulsing err for 1 cycle and staying in IDLE.
REQ-020 SHALL send the image tensor first, then the kernel tensor.
REQ-021 SHALL define the beat count of each tensor as rows*cols, computed at 2*ADDR_WIDTH bits.
REQ-022 SHALL form the element address as base + index, modulo 2^ADDR_WIDTH, so that addresses wrap.
REQ-023 SHALL hold m_axis_tuser at {rows, cols, num_channels} (MSB first) for every beat of the current tensor.
REQ-024 SHALL assert m_axis_tlast only on the final beat of each tensor, so that a job produces exactly 2 tlast beats.
REQ-025 SHALL buffer read data in a 2-entry FIFO that drives the m_axis outputs; m_axis_tvalid SHALL equal FIFO not-empty.
REQ-026 SHALL issue a read when occupancy + in-flight - pop < 2, where pop = tvalid & tready.
REQ-027 SHALL never overflow the FIFO and never drop or duplicate data under any tready pattern.
REQ-028 SHALL keep tdata, tlast and tuser stable while tvalid=1 and tready=0.
REQ-029 SHALL sustain 1 beat per cycle while tready is held at 1.
REQ-030 SHALL make the first tvalid appear exactly 3 cycles after the start-accept edge: mem_rd_en in cycle +1, data capture at edge +2, tvalid in cycle +3.
REQ-031 SHALL stop issuing reads for a tensor once all its addresses have been issued.
REQ-032 SHALL begin kernel reads while image beats are still draining, with no bubble at the tensor boundary.
REQ-033 SHALL enter FINISH on the handshake of the kernel tlast beat, pulse done for 1 cycle, then return to IDLE.
REQ-034 SHALL hold busy=1 from the cycle after start acceptance through FINISH.

Reset
REQ-035 SHALL, when rst=1, immediately and asynchronously force state IDLE, FIFO empty, in-flight 0, and all outputs 0 (m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tuser, mem_rd_en, mem_rd_addr, busy, done, err).
REQ-036 SHALL discard any job in progress on reset; the first start after rst deasserts SHALL behave as a fresh job.

Verification
REQ-037 SHALL pass a basic job: img 2x3, ker 2x2, ch 1, img_base 0, ker_base 100, tready=1 -> 10 beats; addresses 0-5 then 100-103; tlast on beats 6 and 10; tuser {2,3,1} then {2,2,1}; done 1 cycle after the last beat.
REQ-038 SHALL pass a backpressure test: the same job with tready random at 50% -> identical ordered data; stable outputs while stalled; mem_rd_en never asserted when the FIFO plus in-flight count is 2.
REQ-039 SHALL pass a wrap test: ADDR_WIDTH=13, img_base 8190, img 1x4 -> read addresses 8190, 8191, 0, 1.
REQ-040 SHALL pass a rejection test: start with ker_col=0 -> err pulse, busy stays 0, no beats; a start during busy -> ignored, the job completes unchanged.
REQ-041 SHALL pass a reset mid-job: rst asserted after beat 3 -> tvalid 0 in the same cycle, state IDLE; a new start then produces a complete correct job.
REQ-042 SHALL pass a latency test: a start-accept edge at cycle N -> mem_rd_en in cycle N+1 and tvalid in cycle N+3.
